vga_pixel_fetch: RTL

//  Downstream stage of vga_sync. Uses pixel_x/pixel_y/video_on/cnt3 to read an 8-bit grayscale

---
 rtl/vga_pixel_fetch_if.sv | 14 +
 rtl/vga_pixel_fetch.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch_if.sv
// rtl/vga_pixel_fetch_if.sv - BRAM read port between vga_pixel_fetch and the image memory
//   mem_addr   ADDR_W  read address (master -> memory)
//   mem_rd_en  1       one-clk read strobe (master -> memory)
//   mem_data   8       read data, valid MEM_LAT clk after the strobe (memory -> master)
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_data;

  modport master (output mem_addr, output mem_rd_en, input mem_data);
  modport slave  (input mem_addr, input mem_rd_en, output mem_data);
endinterface

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - windowed grayscale BRAM fetch with per-frame display mode for VGA
//   clk, reset           system clock, synchronous active-high reset
//   cnt3                 pixel tick, one clk in four
//   pixel_x, pixel_y     current pixel position from vga_sync
//   video_on             active-area flag
//   hsync_in, vsync_in   syncs from vga_sync
//   mode, thresh         display mode / threshold, latched at frame start
//   mem                  BRAM read port (master side)
//   rgb, hsync, vsync    colour and syncs, one pixel behind the inputs
//   frame_cnt            frames started since reset
module vga_pixel_fetch #(
  parameter int          IMG_W   = 160,
  parameter int          IMG_H   = 120,
  parameter int          X0      = 240,
  parameter int          Y0      = 180,
  parameter int          ADDR_W  = 15,
  parameter int          MEM_LAT = 1,
  parameter logic [11:0] BORDER  = 12'h008
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cnt3,
  input  logic [9:0]               pixel_x,
  input  logic [9:0]               pixel_y,
  input  logic                     video_on,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic [1:0]               mode,
  input  logic [7:0]               thresh,
  vga_pixel_fetch_if.master        mem,
  output logic [11:0]              rgb,
  output logic                     hsync,
  output logic                     vsync,
  output logic [7:0]               frame_cnt
);

  localparam logic [10:0]   X_LO = 11'(X0);
  localparam logic [10:0]   X_HI = 11'(X0 + IMG_W);
  localparam logic [10:0]   Y_LO = 11'(Y0);
  localparam logic [10:0]   Y_HI = 11'(Y0 + IMG_H);
  // One extra bit so a full image of exactly 2**ADDR_W pixels can still hold at "done".
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(IMG_W * IMG_H);

  logic [10:0]       x11, y11;
  logic              in_win, win_start, frame_start;
  logic [1:0]        mode_q, mode_now;
  logic [7:0]        thresh_q, thresh_now;
  logic [ADDR_W:0]   addr_cnt, addr_use;

  // Pixel sampled at the previous tick, waiting for its BRAM byte.
  logic              s_von, s_win, s_hs, s_vs;
  logic [2:0]        s_bar;
  logic [1:0]        s_mode;
  logic [7:0]        s_thresh;
  logic [7:0]        gray_q;
  logic [MEM_LAT-1:0] rd_dly;
  logic [11:0]       pix_rgb;
  logic [3:0]        g_hi;

  assign x11         = {1'b0, pixel_x};
  assign y11         = {1'b0, pixel_y};
  assign in_win      = video_on && (x11 >= X_LO) && (x11 < X_HI) && (y11 >= Y_LO) && (y11 < Y_HI);
  assign win_start   = in_win && (x11 == X_LO) && (y11 == Y_LO);
  assign frame_start = (pixel_x == 10'd0) && (pixel_y == 10'd0);
  // The frame-start pixel itself already uses the freshly latched settings.
  assign mode_now    = frame_start ? mode : mode_q;
  assign thresh_now  = frame_start ? thresh : thresh_q;
  assign addr_use    = win_start ? '0 : addr_cnt;

  always_comb begin
    pix_rgb = 12'h000;
    g_hi    = (s_mode == 2'b01) ? ~gray_q[7:4] : gray_q[7:4];
    if (!s_von) begin
      pix_rgb = 12'h000;
    end else if (!s_win) begin
      pix_rgb = BORDER;
    end else begin
      case (s_mode)
        2'b00, 2'b01: pix_rgb = {g_hi, g_hi, g_hi};
        2'b10:        pix_rgb = (gray_q >= s_thresh) ? 12'hFFF : 12'h000;
        default: begin
          case (s_bar)
            3'd0:    pix_rgb = 12'hFFF;
            3'd1:    pix_rgb = 12'hFF0;
            3'd2:    pix_rgb = 12'h0FF;
            3'd3:    pix_rgb = 12'h0F0;
            default: pix_rgb = 12'hF00;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb           <= '0;
      hsync         <= 1'b0;
      vsync         <= 1'b0;
      frame_cnt     <= '0;
      mem.mem_addr  <= '0;
      mem.mem_rd_en <= 1'b0;
      addr_cnt      <= '0;
      mode_q        <= '0;
      thresh_q      <= '0;
      s_von         <= 1'b0;
      s_win         <= 1'b0;
      s_hs          <= 1'b0;
      s_vs          <= 1'b0;
      s_bar         <= '0;
      s_mode        <= '0;
      s_thresh      <= '0;
      gray_q        <= '0;
      rd_dly        <= '0;
    end else begin
      mem.mem_rd_en <= 1'b0;
      // Strobe delayed by MEM_LAT marks the clk in which mem_data is valid.
      rd_dly <= MEM_LAT'({rd_dly, mem.mem_rd_en});
      if (rd_dly[MEM_LAT-1]) begin
        gray_q <= mem.mem_data;
      end
      if (cnt3) begin
        // Retire the previous pixel, then take in the current one.
        rgb      <= pix_rgb;
        hsync    <= s_hs;
        vsync    <= s_vs;
        s_von    <= video_on;
        s_win    <= in_win;
        s_hs     <= hsync_in;
        s_vs     <= vsync_in;
        s_bar    <= pixel_x[9:7];
        s_mode   <= mode_now;
        s_thresh <= thresh_now;
        if (frame_start) begin
          frame_cnt <= frame_cnt + 8'd1;
          mode_q    <= mode;
          thresh_q  <= thresh;
        end
        if (in_win) begin
          mem.mem_addr  <= addr_use[ADDR_W-1:0];
          mem.mem_rd_en <= (mode_now != 2'b11);
          if (addr_use != LAST) begin
            addr_cnt <= addr_use + 1'b1;
          end
        end
      end
    end
  end

endmodule
